cnt_seq_ctrl: RTL and testbench

Run/pause/clear sequencer for the team's mod-12 counter datapath (Clk, MR, Q[3:0], TC).
- Generates a prescaled count-enable and a clear pulse for the counter.
- Monitors TC to count completed counter periods, and stops the counter after a programmed number of periods.
- Sits between the push-button/control logic and the counter instance.

---
 rtl/cnt_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Run/pause/clear sequencer for a mod-MOD counter: prescaled CE, CNT_CLR pulse, period count.
// Optional shadow-counter consistency checker enabled by defining CNT_CHK_EN.
module cnt_seq_ctrl #(
  parameter int DIV   = 4,
  parameter int MOD   = 12,
  parameter int WRAPS = 3
) (
  input  logic       Clk,
  input  logic       MR,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clr,
  input  logic       TC,
  input  logic [3:0] Q,
  output logic       CE,
  output logic       CNT_CLR,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Wraps,
  output logic       Err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] PRE_LAST  = 8'(DIV - 1);
  localparam logic [3:0] WRAP_LAST = 4'(WRAPS);

  if (DIV < 2 || DIV > 256) begin : g_bad_div
    $error("cnt_seq_ctrl: DIV must be in 2..256");
  end
  if (MOD < 2 || MOD > 16) begin : g_bad_mod
    $error("cnt_seq_ctrl: MOD must be in 2..16");
  end
  if (WRAPS < 1 || WRAPS > 15) begin : g_bad_wraps
    $error("cnt_seq_ctrl: WRAPS must be in 1..15");
  end

  logic [1:0] state;
  logic [7:0] presc;
  logic [3:0] wraps;
  logic [3:0] wraps_nx;
  logic       cnt_clr;
  logic       start_q, stop_q, clr_q;
  logic       start_ev, stop_ev, clr_ev;
  logic       ce, wrap, wrap_last;

  // History keeps sampling through MR so a level held across reset is not seen as a new edge.
  always_ff @(posedge Clk) begin
    start_q <= Start;
    stop_q  <= Stop;
    clr_q   <= Clr;
  end

  assign start_ev = Start & ~start_q;
  assign stop_ev  = Stop  & ~stop_q;
  assign clr_ev   = Clr   & ~clr_q;

  assign ce        = (state == S_RUN) && (presc == PRE_LAST);
  assign wrap      = ce && TC && (wraps < WRAP_LAST);
  assign wraps_nx  = wraps + 4'd1;
  assign wrap_last = wrap && (wraps_nx == WRAP_LAST);

  always_ff @(posedge Clk) begin
    if (MR) begin
      state   <= S_IDLE;
      presc   <= 8'd0;
      wraps   <= 4'd0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= clr_ev;
      if (clr_ev) begin
        state <= S_IDLE;
        presc <= 8'd0;
        wraps <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ev) begin
              state <= S_RUN;
              presc <= 8'd0;
            end
          end
          S_RUN: begin
            // The cycle in which Stop arrives still counts, so resume keeps CE phase.
            presc <= (presc == PRE_LAST) ? 8'd0 : presc + 8'd1;
            if (wrap) wraps <= wraps_nx;
            if (wrap_last)    state <= S_DONE;
            else if (stop_ev) state <= S_PAUSE;
          end
          S_PAUSE: begin
            if (start_ev) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign CE      = ce;
  assign CNT_CLR = cnt_clr;
  assign Busy    = (state == S_RUN) || (state == S_PAUSE);
  assign Done    = (state == S_DONE);
  assign Wraps   = wraps;

`ifdef CNT_CHK_EN
  localparam logic [3:0] SH_LAST = 4'(MOD - 1);

  logic [3:0] shadow;
  logic       err;

  // Shadow follows the same CE/CNT_CLR the counter sees; compare is skipped while it clears.
  always_ff @(posedge Clk) begin
    if (MR) begin
      shadow <= 4'd0;
      err    <= 1'b0;
    end else begin
      if (cnt_clr)  shadow <= 4'd0;
      else if (ce)  shadow <= (shadow == SH_LAST) ? 4'd0 : shadow + 4'd1;
      if (clr_ev)
        err <= 1'b0;
      else if (!cnt_clr && ((Q != shadow) || (TC != (shadow == SH_LAST))))
        err <= 1'b1;
    end
  end

  assign Err = err;
`else
  logic unused_chk;
  assign unused_chk = (^Q) ^ (MOD == 0);
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Randomized bench for cnt_seq_ctrl with an attached mod-12 counter and a count-based reference model.
module tb_cnt_seq_ctrl;
  localparam int DIV   = 4;
  localparam int MOD   = 12;
  localparam int WRAPS = 2;
`ifdef CNT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       mr, start, stop, clr, frc;
  logic [3:0] q, q_drv;
  logic       tc;
  logic       ce, cnt_clr, busy, done, err;
  logic [3:0] wraps;

  cnt_seq_ctrl #(.DIV(DIV), .MOD(MOD), .WRAPS(WRAPS)) dut (
    .Clk(clk), .MR(mr), .Start(start), .Stop(stop), .Clr(clr),
    .TC(tc), .Q(q_drv), .CE(ce), .CNT_CLR(cnt_clr), .Busy(busy),
    .Done(done), .Wraps(wraps), .Err(err)
  );

  // Attached counter, sharing MR with the sequencer
  always_ff @(posedge clk) begin
    if (mr || cnt_clr) q <= 4'd0;
    else if (ce)       q <= (q == 4'(MOD - 1)) ? 4'd0 : q + 4'd1;
  end
  assign tc    = (q == 4'(MOD - 1));
  assign q_drv = frc ? 4'd7 : q;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: mode flags plus total RUN cycles and total CEs since the last clear.
  bit m_valid = 1'b0;
  bit m_run, m_pause, m_done, m_clrp, m_err;
  int m_rc, m_ce, m_qhold;
  bit ps, pp, pc;

  function automatic bit exp_ce();
    return m_run && (m_rc % DIV == DIV - 1);
  endfunction

  task automatic step(input bit m, input bit s, input bit p, input bit c, input bit f);
    bit se, pe, cev, ce_now;
    se = s && !ps;
    pe = p && !pp;
    cev = c && !pc;
    ce_now = exp_ce();
    if (m) begin
      m_run = 0; m_pause = 0; m_done = 0; m_clrp = 0; m_err = 0;
      m_rc = 0; m_ce = 0; m_qhold = 0; m_valid = 1'b1;
    end else begin
      if (CHK && f && !m_clrp && (m_ce % MOD != 7)) m_err = 1;
      if (ce_now) m_ce++;
      m_clrp = cev;
      m_qhold = m_ce % MOD;
      if (cev) begin
        m_run = 0; m_pause = 0; m_done = 0; m_rc = 0; m_ce = 0; m_err = 0;
      end else if (m_run) begin
        m_rc++;
        if (m_ce / MOD >= WRAPS) begin m_run = 0; m_done = 1; end
        else if (pe) begin m_run = 0; m_pause = 1; end
      end else if (m_pause) begin
        if (se) begin m_pause = 0; m_run = 1; end
      end else if (!m_done) begin
        if (se) begin m_run = 1; m_rc = 0; end
      end
    end
    ps = s; pp = p; pc = c;
  endtask

  task automatic cyc(input bit m, input bit s, input bit p, input bit c, input bit f);
    int w, qe;
    @(negedge clk);
    if (m_valid) begin
      w  = m_ce / MOD;
      if (w > WRAPS) w = WRAPS;
      qe = m_clrp ? m_qhold : (m_ce % MOD);
      check("ce",      32'(ce),      32'(exp_ce()));
      check("cnt_clr", 32'(cnt_clr), 32'(m_clrp));
      check("busy",    32'(busy),    32'(m_run | m_pause));
      check("done",    32'(done),    32'(m_done));
      check("wraps",   32'(wraps),   w);
      check("err",     32'(err),     32'(m_err));
      check("q",       32'(q),       qe);
    end
    mr = m; start = s; stop = p; clr = c; frc = f;
    @(posedge clk);
    #1;
    step(m, s, p, c, f);
  endtask

  initial begin
    bit sl, pl, cl, rm, rf;
    mr = 1'b1; start = 1'b1; stop = 1'b0; clr = 1'b0; frc = 1'b0;
    ps = 1'b0; pp = 1'b0; pc = 1'b0;

    // Reset with Start held; no start event after release until a fresh rise
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wraps", 32'(wraps), 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    check("held_start_idle", 32'(busy), 0);
    cyc(0, 0, 0, 0, 0);

    // Full run to DONE, then ignored Start/Stop
    cyc(0, 1, 0, 0, 0);
    repeat (120) cyc(0, 0, 0, 0, 0);
    check("done_reached", 32'(done), 1);
    check("wraps_sat", 32'(wraps), WRAPS);
    repeat (4) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Stop one cycle after the 5th CE, long pause, resume
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (q == 4'd5) break;
    end
    check("stop_point", 32'(q), 5);
    cyc(0, 0, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    check("pause_hold", 32'(q), 5);
    cyc(0, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0);

    // Clr and Start rising together while running
    cyc(0, 1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Checker: corrupt Q while the counter sits at 3, then Clr
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (q == 4'd3) break;
    end
    cyc(0, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Random levels on all controls
    sl = 0; pl = 0; cl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)   sl = !sl;
      if ($urandom_range(0, 24) == 0)  pl = !pl;
      if ($urandom_range(0, 249) == 0) cl = !cl;
      rm = ($urandom_range(0, 999) == 0);
      rf = ($urandom_range(0, 199) == 0);
      cyc(rm, sl, pl, cl, rf);
    end
    cyc(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
